// File: rtl/sipo_frame_deserializer_pkg.sv
// Shared types and helpers for the SIPO frame deserializer (package sipo_pkg).
// Optional parity support is enabled with the PARITY_CHECK_EN macro.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Wide enough to hold WIDTH+1 so the terminal compare never wraps.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic logic even_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sipo_frame_deserializer_bit_counter.sv
// Frame bit counter: load-to-1 on a frame start, increment per accepted bit,
// flags when the next accepted bit is the one that reaches the terminal count.
module sipo_bit_counter #(
  parameter int CNT_W = 4,
  parameter int TERM  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_done
);

  localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == TERM_M1);

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Serial-to-parallel frame capture with valid/ready output and sticky overrun.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit and add parity_err.
module sipo_frame_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_sr_first;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
  logic             w_inc;
  logic             w_clr;
  logic             w_done;
  logic             w_complete;

  sipo_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_inc  (w_inc),
    .i_clr  (w_clr),
    .o_done (w_done)
  );

  always_comb begin
    w_sr_shift = '0;
    w_sr_first = '0;
    if (MSB_FIRST) begin
      w_sr_shift = {r_sr[WIDTH-2:0], d};
      w_sr_first = {{(WIDTH-1){1'b0}}, d};
    end else begin
      w_sr_shift = {d, r_sr[WIDTH-1:1]};
      w_sr_first = {d, {(WIDTH-1){1'b0}}};
    end
  end

`ifdef PARITY_CHECK_EN
  assign w_word = r_sr;
`else
  assign w_word = w_sr_shift;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start with d_valid always restarts the frame, whatever state we are in.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_valid && start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (d_valid && start) begin
          w_load = 1'b1;
        end else if (d_valid) begin
`ifdef PARITY_CHECK_EN
          w_inc = 1'b1;
          if (w_done) begin
            w_state_nxt = PARITY;
          end
`else
          if (w_done) begin
            w_clr       = 1'b1;
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_inc = 1'b1;
          end
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (d_valid && start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else if (d_valid) begin
          w_clr       = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (w_load) begin
      r_sr <= w_sr_first;
    end else if (w_inc) begin
      r_sr <= w_sr_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else if (w_complete) begin
      if (!out_valid || out_ready) begin
        out_data   <= w_word;
        out_valid  <= 1'b1;
`ifdef PARITY_CHECK_EN
        parity_err <= even_parity(32'(r_sr)) ^ d;
`endif
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one input stream.
module tb_sipo_frame_deserializer;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         d;
  logic         d_valid;
  logic         start;
  logic         out_ready;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, ovr_m, ovr_l;
`ifdef PARITY_CHECK_EN
  logic         perr_m, perr_l;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  sipo_frame_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .d_valid   (d_valid),
    .start     (start),
    .out_data  (data_m),
    .out_valid (valid_m),
    .out_ready (out_ready),
`ifdef PARITY_CHECK_EN
    .parity_err(perr_m),
`endif
    .overrun   (ovr_m)
  );

  sipo_frame_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .d_valid   (d_valid),
    .start     (start),
    .out_data  (data_l),
    .out_valid (valid_l),
    .out_ready (out_ready),
`ifdef PARITY_CHECK_EN
    .parity_err(perr_l),
`endif
    .overrun   (ovr_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic dv, input logic st, input logic rdy);
    @(negedge clk);
    d = b; d_valid = dv; start = st; out_ready = rdy;
    @(posedge clk);
    #1;
    if (valid_m) pulses++;
  endtask

  // Bits go out MSB of word first; optional idle gaps after bit 3 and bit 6.
  task automatic send_frame(input logic [7:0] word, input int g3, input int g6,
                            input logic rdy, input logic pflip, input logic chk);
    for (int i = 0; i < W; i++) begin
`ifndef PARITY_CHECK_EN
      if (chk && i == W-1) check("early_valid", valid_m, 1'b0);
`endif
      step(word[W-1-i], 1'b1, i == 0, rdy);
      if (i == 2) repeat (g3) step(1'b0, 1'b0, 1'b0, rdy);
      if (i == 5) repeat (g6) step(1'b0, 1'b0, 1'b0, rdy);
    end
`ifdef PARITY_CHECK_EN
    if (chk) check("early_valid", valid_m, 1'b0);
    step((^word) ^ pflip, 1'b1, 1'b0, rdy);
`endif
  endtask

  typedef struct {
    logic [7:0] word;
    int         g3;
    int         g6;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the random phase.
  logic       mq[$];
  bit         m_in_frame;
  logic       e_valid, e_ovr, e_perr;
  logic [7:0] e_data_m, e_data_l;

  function automatic logic [7:0] word_of(input bit msb);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = mq[i];
      else     w[i]     = mq[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in_frame = 1'b0;
    e_valid = 1'b0; e_ovr = 1'b0; e_perr = 1'b0;
    e_data_m = '0; e_data_l = '0;
  endtask

  task automatic model_edge();
    bit done;
    done = 1'b0;
    if (d_valid) begin
      if (start) begin
        mq.delete();
        mq.push_back(d);
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        mq.push_back(d);
        if (mq.size() == NB) begin
          done = 1'b1;
          m_in_frame = 1'b0;
        end
      end
    end
    if (done) begin
      if (!e_valid || out_ready) begin
        e_data_m = word_of(1'b1);
        e_data_l = word_of(1'b0);
        e_valid  = 1'b1;
        e_perr   = 1'b0;
        foreach (mq[i]) e_perr = e_perr ^ mq[i];
      end else begin
        e_ovr = 1'b1;
      end
    end else if (e_valid && out_ready) begin
      e_valid = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 0, 0, 8'hA5, 8'hA5};
    vecs[1] = '{8'hA5, 3, 1, 8'hA5, 8'hA5};
    vecs[2] = '{8'h01, 0, 0, 8'h01, 8'h80};
    vecs[3] = '{8'h3C, 0, 2, 8'h3C, 8'h3C};
    vecs[4] = '{8'hF0, 1, 0, 8'hF0, 8'h0F};
    vecs[5] = '{8'h12, 0, 0, 8'h12, 8'h48};

    rst = 1'b1; d = 1'b0; d_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    #22;
    check("rst_valid", valid_m, 1'b0);
    check("rst_data", data_m, 8'h00);
    check("rst_overrun", ovr_m, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Start without d_valid, and data without start, must be ignored.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (9) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("ignored_bits", pulses, 0);

    foreach (vecs[k]) begin
      send_frame(vecs[k].word, vecs[k].g3, vecs[k].g6, 1'b1, 1'b0, 1'b1);
      check("tbl_valid_m", valid_m, 1'b1);
      check("tbl_valid_l", valid_l, 1'b1);
      check("tbl_data_m", data_m, vecs[k].exp_m);
      check("tbl_data_l", data_l, vecs[k].exp_l);
      check("tbl_overrun", ovr_m, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("tbl_one_cycle", valid_m, 1'b0);
      check("tbl_data_hold", data_m, vecs[k].exp_m);
    end

`ifdef PARITY_CHECK_EN
    send_frame(8'hA5, 0, 0, 1'b1, 1'b0, 1'b1);
    check("par_ok", perr_m, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 0, 0, 1'b1, 1'b1, 1'b1);
    check("par_err", perr_m, 1'b1);
    check("par_err_data", data_m, 8'hA5);
    check("par_err_valid", valid_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Abort after 4 bits, then a full frame.
    pulses = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h5A, 0, 0, 1'b1, 1'b0, 1'b1);
    check("restart_data", data_m, 8'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_pulses", pulses, 1);

    // Backpressure.
    send_frame(8'h3C, 0, 0, 1'b0, 1'b0, 1'b0);
    check("bp_first_valid", valid_m, 1'b1);
    check("bp_first_ovr", ovr_m, 1'b0);
    send_frame(8'hC3, 0, 0, 1'b0, 1'b0, 1'b0);
    check("bp_data_kept", data_m, 8'h3C);
    check("bp_valid", valid_m, 1'b1);
    check("bp_overrun_m", ovr_m, 1'b1);
    check("bp_overrun_l", ovr_l, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_consumed", valid_m, 1'b0);
    check("bp_ovr_sticky", ovr_m, 1'b1);
    check("bp_data_after", data_m, 8'h3C);

    // Asynchronous reset mid-frame.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_data", data_m, 8'h00);
    check("arst_valid", valid_m, 1'b0);
    check("arst_overrun", ovr_m, 1'b0);
    #1 rst = 1'b0;
    send_frame(8'hF0, 0, 0, 1'b1, 1'b0, 1'b1);
    check("post_rst_data_m", data_m, 8'hF0);
    check("post_rst_data_l", data_l, 8'h0F);
    check("post_rst_valid", valid_m, 1'b1);

    // Random phase against the model.
    @(negedge clk);
    d_valid = 1'b0; start = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      d         = 1'($urandom_range(0, 1));
      d_valid   = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 13) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      model_edge();
      @(posedge clk);
      #1;
      check("rnd_valid_m", valid_m, e_valid);
      check("rnd_valid_l", valid_l, e_valid);
      check("rnd_data_m", data_m, e_data_m);
      check("rnd_data_l", data_l, e_data_l);
      check("rnd_overrun", ovr_m, e_ovr);
`ifdef PARITY_CHECK_EN
      check("rnd_perr", perr_m, e_perr);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_deserializer.md
Name: sipo_frame_deserializer

Overview:
- Serial-to-parallel capture stage that sits directly downstream of the single-bit D flop.
- Consumes the flop's registered output bit stream, framed by a start pulse and qualified by a valid strobe.
- Assembles WIDTH-bit words and presents them on a valid/ready output interface.
- Reports overrun when the consumer stalls.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  1  serial data bit (registered q of the upstream D flop).
- d_valid  input  1  d is sampled on an edge only when d_valid=1.
- start  input  1  marks the first bit of a frame; honoured only together with d_valid=1.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word on an edge where out_valid=1 and out_ready=1.
- overrun  output  1  sticky; a completed word was dropped.
- parity_err  output  1  present only with PARITY_CHECK_EN (see below).

Behaviour:
- Reset is asynchronous on rst=1:
  - state=IDLE; shift register, bit counter, out_data, out_valid, overrun and parity_err all go to 0.
  - Reset takes effect immediately, also mid-frame. The partial word is discarded.
- States are IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- IDLE:
  - On an edge with start=1 and d_valid=1, d is captured as bit 0, cnt=1, next state is SHIFT.
  - Bits with start=0 are ignored. start with d_valid=0 is ignored.
- SHIFT:
  - Each edge with d_valid=1 shifts d into the next position and increments cnt. Edges with d_valid=0 hold all state.
  - start=1 with d_valid=1 in SHIFT aborts the frame: the partial word is discarded, d becomes bit 0, cnt=1, no output is produced.
- Completion is the edge that accepts bit WIDTH-1 (cnt reaches WIDTH):
  - Without parity: the word is delivered on that same edge and the next state is IDLE. A new frame's start is accepted on the very next edge.
  - Latency: out_valid rises one clock after the last bit is presented.
- Delivery at the completion edge:
  - If out_valid=0, or out_ready=1 (the old word is consumed this edge): out_data <= new word, out_valid <= 1.
  - If out_valid=1 and out_ready=0: the new word is dropped, out_data and out_valid are unchanged, overrun <= 1.
- Output handshake outside completion:
  - out_valid=1 and out_ready=1 at an edge clears out_valid; out_data holds its last value.
  - out_ready is ignored while out_valid=0.
- overrun is cleared only by rst.
- Width rules:
  - cnt is $clog2(WIDTH+2) bits and is compared against WIDTH, so there is no wrap-around.
  - The shift register is exactly WIDTH bits.

Optional Feature:
- Macro PARITY_CHECK_EN.
- When defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - After the last data bit the state goes to PARITY. The edge accepting the parity bit (d_valid=1) is the completion edge, so latency grows by one accepted bit.
  - parity_err is registered together with the out_data load: 1 if XOR(data bits, parity bit) = 1.
  - On a dropped word (overrun), parity_err is unchanged.
  - start during PARITY aborts, same as in SHIFT.
  - The word is delivered even when parity_err=1.
- When undefined: no PARITY state, no parity_err port, behaviour exactly as above.

Decomposition:
- Shared package sipo_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - constant CNT_W function of WIDTH;
  - the even-parity helper function.
- One natural sub-module, sipo_bit_counter:
  - loadable counter with a load-to-1 on start and increment on d_valid;
  - done flag at the programmed terminal count.
- The FSM and output register stay in the top module.

Test Plan:
- MSB_FIRST=1, out_ready=1, frame bits 1,0,1,0,0,1,0,1 on consecutive edges with d_valid=1 and start on the first -> out_valid=1 for exactly one cycle after the 8th edge, out_data=8'hA5, overrun=0.
- Same frame with d_valid=0 for 3 cycles after bit 3 and for 1 cycle after bit 6 -> out_data=8'hA5, out_valid delayed by 4 cycles. With MSB_FIRST=0 the same bits give 8'hA5 reversed = 8'hA5 (palindromic); also send 8'h01 MSB-first bits, which gives 8'h80.
- Backpressure: out_ready=0, send 8'h3C then 8'hC3 -> out_data stays 8'h3C, out_valid=1, overrun=1 after the second frame. Then out_ready=1 for one edge -> out_valid=0, overrun stays 1.
- Restart: 4 bits of a frame, then start with new frame 8'h5A -> only 8'h5A is delivered, exactly one out_valid pulse.
- Reset mid-frame: rst pulse after 3 bits -> all outputs 0 immediately (asynchronously, before the next edge). The following frame 8'hF0 is delivered correctly.
- PARITY_CHECK_EN: 8'hA5 + parity bit 0 -> parity_err=0. 8'hA5 + parity bit 1 -> parity_err=1, out_data=8'hA5.
